// File: rtl/text_overlay.sv
// Two-line, 16-character text window drawn at 2x scale; 3-clock pipeline out to the font ROM and back.
// Optional build macro TEXT_BLINK_EN: line 1 blinks on a 64-frame period (32 frames on, 32 off).
module text_overlay #(
    parameter int ORIGIN_X = 256,
    parameter int ORIGIN_Y = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       video_on_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [1:0] screen_sel,
    output logic [7:0] ascii,
    output logic [3:0] row,
    input  logic [7:0] pixels,
    output logic       text_on,
    output logic       video_on_out,
    output logic       hsync_out,
    output logic       vsync_out
);
    localparam logic [10:0] X_LO  = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI  = 11'(ORIGIN_X + 256);
    localparam logic [10:0] Y0_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y0_HI = 11'(ORIGIN_Y + 16);
    localparam logic [10:0] Y1_LO = 11'(ORIGIN_Y + 32);
    localparam logic [10:0] Y1_HI = 11'(ORIGIN_Y + 48);

    localparam logic [127:0] STR_TITLE = "    BREAKOUT    ";
    localparam logic [127:0] STR_LOST  = "    YOU LOST    ";
    localparam logic [127:0] STR_WON   = "   YOU WIN )    ";
    localparam logic [127:0] STR_START = "  PRESS START   ";
    localparam logic [127:0] STR_BLANK = "                ";

    // Character 0 sits in the top byte of the packed string literal.
    function automatic logic [7:0] glyph(input logic [1:0] scr, input logic line1,
                                         input logic [3:0] idx);
        logic [127:0] s;
        if (scr == 2'd3)      s = STR_BLANK;
        else if (line1)       s = STR_START;
        else if (scr == 2'd0) s = STR_TITLE;
        else if (scr == 2'd1) s = STR_LOST;
        else                  s = STR_WON;
        return s[{~idx, 3'b000} +: 8];
    endfunction

    logic [10:0] x_w, y_w;
    logic        in_x, on_l0, on_l1, in_win;
    logic [6:0]  dx_half;
    logic [2:0]  dy_half;

    assign x_w    = {1'b0, x};
    assign y_w    = {1'b0, y};
    assign in_x   = (x_w >= X_LO) && (x_w < X_HI);
    assign on_l0  = (y_w >= Y0_LO) && (y_w < Y0_HI);
    assign on_l1  = (y_w >= Y1_LO) && (y_w < Y1_HI);
    assign in_win = in_x && (on_l0 || on_l1);
    // Line 1 is 32 rows below line 0, so both lines share the same low 4 bits of dy.
    assign dx_half = 7'((x[7:0] - 8'(ORIGIN_X)) >> 1);
    assign dy_half = 3'((y[3:0] - 4'(ORIGIN_Y)) >> 1);

    logic [7:0] ascii_q, ascii_d;
    logic [3:0] row_q, row_d;
    logic [2:0] bit_s1_q, bit_s2_q;
    logic       flag_s1_q, flag_s2_q, flag_d;
    logic       vis_s1_q, vis_s2_q, vis_d;
    logic       text_on_q;
    logic [2:0] vid_q, hs_q, vs_q;
    logic [1:0] screen_q, screen_d;
    logic       vsync_prev_q;
    logic       vsync_fall;

    assign vsync_fall = vsync_prev_q & ~vsync_in;

    always_comb begin
        ascii_d  = 8'h20;
        row_d    = 4'd0;
        flag_d   = 1'b0;
        if (in_win) begin
            ascii_d = glyph(screen_q, on_l1, dx_half[6:3]);
            row_d   = {1'b0, dy_half};
            flag_d  = video_on_in & (screen_q != 2'd3);
        end
        screen_d = vsync_fall ? screen_sel : screen_q;
    end

`ifdef TEXT_BLINK_EN
    logic [5:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (vsync_fall)
            frame_cnt_d = (screen_sel != screen_q) ? 6'd0 : frame_cnt_q + 6'd1;
    end

    assign vis_d = on_l0 | ~frame_cnt_q[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= 6'd0;
        else        frame_cnt_q <= frame_cnt_d;
    end
`else
    assign vis_d = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ascii_q      <= 8'h20;
            row_q        <= 4'd0;
            bit_s1_q     <= 3'd0;
            flag_s1_q    <= 1'b0;
            vis_s1_q     <= 1'b0;
            bit_s2_q     <= 3'd0;
            flag_s2_q    <= 1'b0;
            vis_s2_q     <= 1'b0;
            text_on_q    <= 1'b0;
            vid_q        <= 3'b000;
            hs_q         <= 3'b111;
            vs_q         <= 3'b111;
            screen_q     <= 2'd0;
            vsync_prev_q <= 1'b1;
        end else begin
            ascii_q      <= ascii_d;
            row_q        <= row_d;
            bit_s1_q     <= dx_half[2:0];
            flag_s1_q    <= flag_d;
            vis_s1_q     <= vis_d;
            bit_s2_q     <= bit_s1_q;
            flag_s2_q    <= flag_s1_q;
            vis_s2_q     <= vis_s1_q;
            // ~bit selects pixels[7-bit]: bit 7 of the ROM row is the leftmost pixel.
            text_on_q    <= flag_s2_q & pixels[~bit_s2_q] & vis_s2_q;
            vid_q        <= {vid_q[1:0], video_on_in};
            hs_q         <= {hs_q[1:0], hsync_in};
            vs_q         <= {vs_q[1:0], vsync_in};
            screen_q     <= screen_d;
            vsync_prev_q <= vsync_in;
        end
    end

    assign ascii        = ascii_q;
    assign row          = row_q;
    assign text_on      = text_on_q;
    assign video_on_out = vid_q[2];
    assign hsync_out    = hs_q[2];
    assign vsync_out    = vs_q[2];
endmodule

// File: tb/tb_text_overlay.sv
// Self-checking bench for text_overlay: registered font ROM model plus a frame-level reference model.
module tb_text_overlay;
    localparam int OX = 256;
    localparam int OY = 160;
`ifdef TEXT_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk, rst_n;
    logic [9:0] x, y;
    logic       video_on_in, hsync_in, vsync_in;
    logic [1:0] screen_sel;
    logic [7:0] ascii, pixels;
    logic [3:0] row;
    logic       text_on, video_on_out, hsync_out, vsync_out;

    int n_checks = 0;
    int n_errors = 0;

    text_overlay #(.ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .screen_sel(screen_sel), .ascii(ascii), .row(row), .pixels(pixels),
        .text_on(text_on), .video_on_out(video_on_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Font: blank space, the "B" top row the overlay must reproduce, otherwise a lit-left pattern.
    function automatic logic [7:0] font(input logic [7:0] a, input logic [3:0] r);
        if (a == 8'h20) return 8'h00;
        if (a == 8'h42 && r == 4'd0) return 8'hFC;
        return {1'b1, a[6:0] ^ {r[2:0], r[2:0], 1'b0}};
    endfunction

    always @(posedge clk) pixels <= font(ascii, row);

    function automatic logic [7:0] tb_char(input int scr, input int line, input int idx);
        string s;
        if (scr == 3)       s = "                ";
        else if (line == 1) s = "  PRESS START   ";
        else if (scr == 0)  s = "    BREAKOUT    ";
        else if (scr == 1)  s = "    YOU LOST    ";
        else                s = "   YOU WIN )    ";
        return s[idx];
    endfunction

    // Reference-model state: expected outputs in flight, plus latched screen / frame count.
    logic       e_text[3], e_vid[3], e_hs[3], e_vs[3];
    logic [7:0] p_ascii;
    logic [3:0] p_row;
    int         m_screen, m_cnt;
    logic       m_vsprev;
    logic       c_text, c_vid, c_hs, c_vs;
    logic [7:0] c_ascii;
    logic [3:0] c_row;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            e_text[i] = 1'b0; e_vid[i] = 1'b0; e_hs[i] = 1'b1; e_vs[i] = 1'b1;
        end
        p_ascii = 8'h20; p_row = 4'd0;
        m_screen = 0; m_cnt = 0; m_vsprev = 1'b1;
    endtask

    // At each falling edge: take the outputs expected now, then present new inputs to the DUT and model.
    task automatic drive(input int xv, input int yv, input logic von, input logic hs,
                         input logic vs, input logic [1:0] sel);
        logic inx, l0, l1, win, vis, lit;
        logic [7:0] ch, fr;
        logic [3:0] rw;
        int bp;
        @(negedge clk);
        c_text = e_text[2]; c_vid = e_vid[2]; c_hs = e_hs[2]; c_vs = e_vs[2];
        c_ascii = p_ascii; c_row = p_row;
        for (int i = 2; i > 0; i--) begin
            e_text[i] = e_text[i-1]; e_vid[i] = e_vid[i-1];
            e_hs[i] = e_hs[i-1]; e_vs[i] = e_vs[i-1];
        end
        inx = (xv >= OX) && (xv < OX + 256);
        l0  = (yv >= OY) && (yv < OY + 16);
        l1  = (yv >= OY + 32) && (yv < OY + 48);
        win = inx && (l0 || l1);
        ch  = win ? tb_char(m_screen, l1 ? 1 : 0, (xv - OX) / 16) : 8'h20;
        rw  = win ? 4'(((l0 ? yv - OY : yv - OY - 32) % 16) / 2) : 4'd0;
        vis = l0 || !BLINK || (m_cnt < 32);
        fr  = font(ch, rw);
        bp  = win ? 7 - ((xv - OX) % 16) / 2 : 0;
        lit = win && (m_screen != 3) && von && vis && fr[bp];
        e_text[0] = lit; e_vid[0] = von; e_hs[0] = hs; e_vs[0] = vs;
        p_ascii = ch; p_row = rw;
        if (m_vsprev && !vs) begin
            m_cnt = (int'(sel) != m_screen) ? 0 : (m_cnt + 1) % 64;
            m_screen = int'(sel);
        end
        m_vsprev = vs;
        x = 10'(xv); y = 10'(yv);
        video_on_in = von; hsync_in = hs; vsync_in = vs; screen_sel = sel;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (ascii !== 8'h20) begin n_errors++; $display("FAIL reset_ascii got %h exp 20", ascii); end
        n_checks++; if (row !== 4'd0) begin n_errors++; $display("FAIL reset_row got %0d exp 0", row); end
        n_checks++; if (text_on !== 1'b0) begin n_errors++; $display("FAIL reset_text_on got %b exp 0", text_on); end
        n_checks++; if (video_on_out !== 1'b0) begin n_errors++; $display("FAIL reset_video got %b exp 0", video_on_out); end
        n_checks++; if (hsync_out !== 1'b1) begin n_errors++; $display("FAIL reset_hsync got %b exp 1", hsync_out); end
        n_checks++; if (vsync_out !== 1'b1) begin n_errors++; $display("FAIL reset_vsync got %b exp 1", vsync_out); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_glyph_b();
        logic [15:0] pat;
        do_reset();
        drive(OX, OY, 1, 1, 1, 0);
        drive(OX, OY, 1, 1, 1, 0);
        n_checks++; if (ascii !== 8'h20 || row !== 4'd0) begin
            n_errors++; $display("FAIL origin_glyph got %h/%0d exp 20/0", ascii, row); end
        pat = '0;
        for (int i = 0; i < 19; i++) begin
            drive(i < 16 ? OX + 64 + i : 0, OY, 1, 1, 1, 0);
            if (i == 1) begin
                n_checks++; if (ascii !== 8'h42) begin n_errors++; $display("FAIL b_ascii got %h exp 42", ascii); end
            end
            if (i >= 3) pat[15 - (i - 3)] = text_on;
            n_checks++; if (text_on !== c_text) begin
                n_errors++; $display("FAIL b_text_on step %0d got %b exp %b", i, text_on, c_text); end
        end
        n_checks++; if (pat !== 16'b1111111111110000) begin
            n_errors++; $display("FAIL b_pattern got %b exp 1111111111110000", pat); end
    endtask

    task automatic test_random();
        int xv, yv;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            xv = OX - 8 + int'($urandom_range(0, 272));
            yv = OY - 4 + int'($urandom_range(0, 56));
            drive(xv, yv, ($urandom % 8) != 0, $urandom % 2, ($urandom % 16) != 0,
                  2'($urandom % 4));
            n_checks++; if (text_on !== c_text) begin n_errors++; $display("FAIL rand_text_on cyc %0d got %b exp %b", i, text_on, c_text); end
            n_checks++; if (video_on_out !== c_vid) begin n_errors++; $display("FAIL rand_video cyc %0d got %b exp %b", i, video_on_out, c_vid); end
            n_checks++; if (hsync_out !== c_hs) begin n_errors++; $display("FAIL rand_hsync cyc %0d got %b exp %b", i, hsync_out, c_hs); end
            n_checks++; if (vsync_out !== c_vs) begin n_errors++; $display("FAIL rand_vsync cyc %0d got %b exp %b", i, vsync_out, c_vs); end
            n_checks++; if (ascii !== c_ascii) begin n_errors++; $display("FAIL rand_ascii cyc %0d got %h exp %h", i, ascii, c_ascii); end
            n_checks++; if (row !== c_row) begin n_errors++; $display("FAIL rand_row cyc %0d got %0d exp %0d", i, row, c_row); end
        end
    endtask

    task automatic test_screen_change();
        do_reset();
        repeat (3) drive(OX + 64, OY, 1, 1, 1, 0);
        n_checks++; if (ascii !== 8'h42) begin n_errors++; $display("FAIL scr_title got %h exp 42", ascii); end
        repeat (3) drive(OX + 64, OY, 1, 1, 1, 1);
        n_checks++; if (ascii !== 8'h42) begin n_errors++; $display("FAIL scr_midframe got %h exp 42", ascii); end
        drive(OX + 64, OY, 1, 1, 0, 1);
        drive(OX + 64, OY, 1, 1, 1, 1);
        n_checks++; if (ascii !== c_ascii) begin n_errors++; $display("FAIL scr_edge got %h exp %h", ascii, c_ascii); end
        drive(OX + 64, OY, 1, 1, 1, 1);
        n_checks++; if (ascii !== 8'h59) begin n_errors++; $display("FAIL scr_lost got %h exp 59", ascii); end
    endtask

    task automatic test_hsync();
        int first_low, low_cnt;
        do_reset();
        first_low = -1; low_cnt = 0;
        for (int i = 0; i < 106; i++) begin
            drive(0, 0, 1, (i >= 2 && i < 98) ? 1'b0 : 1'b1, 1, 0);
            n_checks++; if (hsync_out !== c_hs) begin n_errors++; $display("FAIL hs_step %0d got %b exp %b", i, hsync_out, c_hs); end
            if (hsync_out === 1'b0) begin
                if (first_low < 0) first_low = i;
                low_cnt++;
            end
        end
        n_checks++; if (first_low != 5) begin n_errors++; $display("FAIL hs_start got %0d exp 5", first_low); end
        n_checks++; if (low_cnt != 96) begin n_errors++; $display("FAIL hs_width got %0d exp 96", low_cnt); end
    endtask

    task automatic test_blink();
        logic want;
        do_reset();
        for (int f = 0; f <= 64; f++) begin
            repeat (4) drive(OX + 32, OY + 32, 1, 1, 1, 0);
            want = BLINK ? ((f % 64) < 32) : 1'b1;
            n_checks++; if (text_on !== want || text_on !== c_text) begin
                n_errors++; $display("FAIL blink frame %0d got %b exp %b", f, text_on, want); end
            drive(OX + 32, OY + 32, 1, 1, 0, 0);
            drive(OX + 32, OY + 32, 1, 1, 1, 0);
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        repeat (4) drive(OX + 64, OY, 1, 0, 1, 0);
        n_checks++; if (text_on !== 1'b1 || hsync_out !== 1'b0) begin
            n_errors++; $display("FAIL rm_pre got %b/%b exp 1/0", text_on, hsync_out); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (text_on !== 1'b0 || hsync_out !== 1'b1 || ascii !== 8'h20) begin
            n_errors++; $display("FAIL rm_async got %b/%b/%h exp 0/1/20", text_on, hsync_out, ascii); end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(OX + 64, OY, 1, 0, 1, 0);
            n_checks++; if (text_on !== ((i == 4) ? 1'b1 : 1'b0) || text_on !== c_text) begin
                n_errors++; $display("FAIL rm_refill %0d got %b exp %b", i, text_on, c_text); end
        end
        n_checks++; if (ascii !== 8'h42) begin n_errors++; $display("FAIL rm_ascii got %h exp 42", ascii); end
    endtask

    initial begin
        rst_n = 1'b0;
        x = '0; y = '0;
        video_on_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; screen_sel = 2'd0;
        model_reset();
        test_reset();
        test_glyph_b();
        test_random();
        test_screen_change();
        test_hsync();
        test_blink();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
